// File: rtl/queue_pkg.sv
// Shared helpers for the multi-lane FIFO: modulo pointer add and popcount.
package queue_pkg;

  // Circular add: ptr < depth and delta <= depth, so at most one subtraction folds it back.
  function automatic int unsigned ptr_add(input int unsigned ptr,
                                          input int unsigned delta,
                                          input int unsigned depth);
    int unsigned sum;
    sum = ptr + delta;
    if (sum >= depth) sum = sum - depth;
    return sum;
  endfunction

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int b = 0; b < 32; b++) n = n + int'(v[b]);
    return n;
  endfunction

endpackage

// File: rtl/mport_fifo_ptr_ctrl.sv
// Pointer/occupancy control for the multi-lane FIFO: lane ranking, fire generation,
// wrap-around pointer update and flush/reset handling.
module mport_fifo_ptr_ctrl
  import queue_pkg::*;
#(
  parameter int Depth    = 8,
  parameter int EnqWidth = 2,
  parameter int DeqWidth = 2,
  parameter int PtrWidth = $clog2(Depth),
  parameter int CntWidth = $clog2(Depth + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic [EnqWidth-1:0]                enq_valid_i,
  output logic [EnqWidth-1:0]                enq_ready_o,
  input  logic [DeqWidth-1:0]                deq_ready_i,
  output logic [DeqWidth-1:0]                deq_valid_o,
  output logic [EnqWidth-1:0]                wr_en_o,
  output logic [EnqWidth-1:0][PtrWidth-1:0]  wr_addr_o,
  output logic [PtrWidth-1:0]                rd_ptr_o,
  output logic [CntWidth-1:0]                count_o
);

  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic [CntWidth-1:0] count, free, rank, n_enq, n_deq;
  logic [EnqWidth-1:0] enq_fire;
  logic [DeqWidth-1:0] deq_fire;
  logic                prev_fire;

  // Free slots come only from the registered count; same-cycle dequeues give no credit.
  assign free = CntWidth'(Depth) - count;

  // Enqueue ranking: valid lanes are compacted, so a lane's slot offset is the number of
  // valid lanes below it, and it is ready only if that many slots plus itself fit.
  always_comb begin
    enq_ready_o = '0;
    enq_fire    = '0;
    wr_addr_o   = '0;
    rank        = '0;
    for (int i = 0; i < EnqWidth; i++) begin
      enq_ready_o[i] = ~flush_i & (free > rank);
      enq_fire[i]    = enq_valid_i[i] & enq_ready_o[i];
      wr_addr_o[i]   = PtrWidth'(ptr_add(32'(wr_ptr), 32'(rank), Depth));
      if (enq_valid_i[i]) rank = rank + CntWidth'(1);
    end
    n_enq = CntWidth'(popcount(32'(enq_fire)));
  end

  // Dequeue: lane i presents the i-th oldest entry; retirement is strictly in order.
  always_comb begin
    deq_valid_o = '0;
    deq_fire    = '0;
    prev_fire   = 1'b1;
    for (int i = 0; i < DeqWidth; i++) begin
      deq_valid_o[i] = ~flush_i & (count > CntWidth'(i));
      deq_fire[i]    = deq_valid_o[i] & deq_ready_i[i] & prev_fire;
      prev_fire      = deq_fire[i];
    end
    n_deq = CntWidth'(popcount(32'(deq_fire)));
  end

  // Fires during the reset cycle are dropped, so the array is not written either.
  assign wr_en_o = rst ? '0 : enq_fire;

  // Pointer and occupancy update; reset and flush both discard everything at this edge.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= PtrWidth'(ptr_add(32'(wr_ptr), 32'(n_enq), Depth));
      rd_ptr <= PtrWidth'(ptr_add(32'(rd_ptr), 32'(n_deq), Depth));
      count  <= count + n_enq - n_deq;
    end
  end

  assign rd_ptr_o = rd_ptr;
  assign count_o  = count;

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CntWidth'(Depth));
  a_deq_in_order: assert property (@(posedge clk) disable iff (rst)
    ((deq_fire + DeqWidth'(1)) & deq_fire) == '0);
  a_ptr_consistent: assert property (@(posedge clk) disable iff (rst)
    32'(wr_ptr) == ptr_add(32'(rd_ptr), 32'(count), Depth));

endmodule

// File: rtl/mport_fifo_storage.sv
// Multi-lane in-order FIFO payload buffer: flop array written by ranked enqueue lanes,
// read through a per-lane mux starting at the read pointer.
module mport_fifo_storage
  import queue_pkg::*;
#(
  parameter int Depth     = 8,
  parameter int EnqWidth  = 2,
  parameter int DeqWidth  = 2,
  parameter int DataWidth = 32,
  parameter int PtrWidth  = $clog2(Depth),
  parameter int CntWidth  = $clog2(Depth + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [EnqWidth-1:0]                 enq_valid_i,
  output logic [EnqWidth-1:0]                 enq_ready_o,
  input  logic [EnqWidth-1:0][DataWidth-1:0]  enq_data_i,
  output logic [DeqWidth-1:0]                 deq_valid_o,
  input  logic [DeqWidth-1:0]                 deq_ready_i,
  output logic [DeqWidth-1:0][DataWidth-1:0]  deq_data_o,
  input  logic                                flush_i,
  output logic [CntWidth-1:0]                 count_o,
  output logic                                full_o,
  output logic                                empty_o
);

  logic [DataWidth-1:0]               mem [Depth];
  logic [EnqWidth-1:0]                wr_en;
  logic [EnqWidth-1:0][PtrWidth-1:0]  wr_addr;
  logic [PtrWidth-1:0]                rd_ptr;

  mport_fifo_ptr_ctrl #(
    .Depth    (Depth),
    .EnqWidth (EnqWidth),
    .DeqWidth (DeqWidth),
    .PtrWidth (PtrWidth),
    .CntWidth (CntWidth)
  ) u_ptr_ctrl (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .enq_valid_i (enq_valid_i),
    .enq_ready_o (enq_ready_o),
    .deq_ready_i (deq_ready_i),
    .deq_valid_o (deq_valid_o),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .rd_ptr_o    (rd_ptr),
    .count_o     (count_o)
  );

  // Payload write: fired lanes always target distinct entries, contents are never reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < EnqWidth; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= enq_data_i[i];
    end
  end

  // Read mux: lane i shows the entry i places past the read pointer.
  always_comb begin
    deq_data_o = '0;
    for (int i = 0; i < DeqWidth; i++) begin
      deq_data_o[i] = mem[PtrWidth'(ptr_add(32'(rd_ptr), i, Depth))];
    end
  end

  assign full_o  = (count_o == CntWidth'(Depth));
  assign empty_o = (count_o == '0);

endmodule

// File: tb/tb_mport_fifo_storage.sv
// Directed bench for mport_fifo_storage: Depth=8 instance for handshake, full, in-order
// retire, flush and reset; Depth=6 instance for wrap-around streaming.
module tb_mport_fifo_storage;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Depth=8 instance
  logic [1:0]       enq_valid8, enq_ready8, deq_valid8, deq_ready8;
  logic [1:0][31:0] enq_data8, deq_data8;
  logic             flush8, full8, empty8;
  logic [3:0]       count8;

  // Depth=6 instance
  logic [1:0]       enq_valid6, enq_ready6, deq_valid6, deq_ready6;
  logic [1:0][31:0] enq_data6, deq_data6;
  logic             flush6, full6, empty6;
  logic [2:0]       count6;

  mport_fifo_storage #(.Depth(8), .EnqWidth(2), .DeqWidth(2), .DataWidth(32)) u_dut8 (
    .clk         (clk),
    .rst         (rst),
    .enq_valid_i (enq_valid8),
    .enq_ready_o (enq_ready8),
    .enq_data_i  (enq_data8),
    .deq_valid_o (deq_valid8),
    .deq_ready_i (deq_ready8),
    .deq_data_o  (deq_data8),
    .flush_i     (flush8),
    .count_o     (count8),
    .full_o      (full8),
    .empty_o     (empty8)
  );

  mport_fifo_storage #(.Depth(6), .EnqWidth(2), .DeqWidth(2), .DataWidth(32)) u_dut6 (
    .clk         (clk),
    .rst         (rst),
    .enq_valid_i (enq_valid6),
    .enq_ready_o (enq_ready6),
    .enq_data_i  (enq_data6),
    .deq_valid_o (deq_valid6),
    .deq_ready_i (deq_ready6),
    .deq_data_o  (deq_data6),
    .flush_i     (flush6),
    .count_o     (count6),
    .full_o      (full6),
    .empty_o     (empty6)
  );

  int vectors    = 0;
  int miscompares = 0;

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive8(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                        input logic [1:0] dr, input logic fl);
    enq_valid8   = ev;
    enq_data8[0] = d0;
    enq_data8[1] = d1;
    deq_ready8   = dr;
    flush8       = fl;
    #1;
  endtask

  int in_next, out_next;

  initial begin
    rst = 1'b1;
    enq_valid8 = '0; enq_data8 = '0; deq_ready8 = '0; flush8 = 1'b0;
    enq_valid6 = '0; enq_data6 = '0; deq_ready6 = '0; flush6 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;

    // Reset state
    check_vec("rst_enq_ready", 64'(enq_ready8), 64'h3);
    check_vec("rst_deq_valid", 64'(deq_valid8), 64'h0);
    check_vec("rst_count",     64'(count8),     64'h0);
    check_vec("rst_empty",     64'(empty8),     64'h1);
    check_vec("rst_full",      64'(full8),      64'h0);
    check_vec("rst6_count",    64'(count6),     64'h0);

    // Lane 1 only: compacted into entry 0, visible next cycle
    drive8(2'b10, 32'h0, 32'hA, 2'b00, 1'b0);
    check_vec("gap_enq_ready", 64'(enq_ready8), 64'h3);
    check_vec("gap_no_bypass", 64'(deq_valid8), 64'h0);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("gap_count",     64'(count8),       64'h1);
    check_vec("gap_deq_valid", 64'(deq_valid8),   64'h1);
    check_vec("gap_deq_data",  64'(deq_data8[0]), 64'hA);
    check_vec("gap_empty",     64'(empty8),       64'h0);

    // Fill to 7 with pairs 0x10..0x15
    for (int k = 0; k < 3; k++) begin
      drive8(2'b11, 32'(16 + 2 * k), 32'(17 + 2 * k), 2'b00, 1'b0);
      check_vec("fill_enq_ready", 64'(enq_ready8), 64'h3);
      tick();
    end
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("fill_count7", 64'(count8), 64'h7);

    // Near full: only lane 0 fits
    drive8(2'b11, 32'h16, 32'h17, 2'b00, 1'b0);
    check_vec("nearfull_enq_ready", 64'(enq_ready8), 64'h1);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("full_count", 64'(count8), 64'h8);
    check_vec("full_flag",  64'(full8),  64'h1);

    // Full with concurrent dequeue: no same-cycle credit
    drive8(2'b11, 32'h99, 32'h98, 2'b11, 1'b0);
    check_vec("full_enq_ready", 64'(enq_ready8),   64'h0);
    check_vec("full_deq_valid", 64'(deq_valid8),   64'h3);
    check_vec("full_deq_d0",    64'(deq_data8[0]), 64'hA);
    check_vec("full_deq_d1",    64'(deq_data8[1]), 64'h10);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("after_full_count", 64'(count8),       64'h6);
    check_vec("after_full_d0",    64'(deq_data8[0]), 64'h11);
    check_vec("after_full_d1",    64'(deq_data8[1]), 64'h12);

    // Drain to 3 entries (0x14,0x15,0x16)
    drive8(2'b00, 32'h0, 32'h0, 2'b11, 1'b0);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("drain_count3", 64'(count8),       64'h3);
    check_vec("drain_head",   64'(deq_data8[0]), 64'h14);

    // Lane 0 not ready blocks lane 1
    drive8(2'b00, 32'h0, 32'h0, 2'b10, 1'b0);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("blocked_count", 64'(count8),       64'h3);
    check_vec("blocked_head",  64'(deq_data8[0]), 64'h14);

    drive8(2'b00, 32'h0, 32'h0, 2'b01, 1'b0);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("retire1_count", 64'(count8),       64'h2);
    check_vec("retire1_d0",    64'(deq_data8[0]), 64'h15);
    check_vec("retire1_d1",    64'(deq_data8[1]), 64'h16);

    // Build count 5, then flush with concurrent traffic
    drive8(2'b11, 32'h20, 32'h21, 2'b00, 1'b0);
    tick();
    drive8(2'b01, 32'h22, 32'h0, 2'b00, 1'b0);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("preflush_count", 64'(count8), 64'h5);
    drive8(2'b11, 32'h40, 32'h41, 2'b11, 1'b1);
    check_vec("flush_enq_ready", 64'(enq_ready8), 64'h0);
    check_vec("flush_deq_valid", 64'(deq_valid8), 64'h0);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("postflush_count",     64'(count8),     64'h0);
    check_vec("postflush_empty",     64'(empty8),     64'h1);
    check_vec("postflush_enq_ready", 64'(enq_ready8), 64'h3);

    // Build count 5 again, then reset mid-traffic
    drive8(2'b11, 32'h30, 32'h31, 2'b00, 1'b0);
    tick();
    drive8(2'b11, 32'h32, 32'h33, 2'b00, 1'b0);
    tick();
    drive8(2'b01, 32'h34, 32'h0, 2'b00, 1'b0);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("prerst_count", 64'(count8), 64'h5);
    rst = 1'b1;
    drive8(2'b11, 32'h50, 32'h51, 2'b11, 1'b0);
    tick();
    rst = 1'b0;
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("postrst_count",     64'(count8),     64'h0);
    check_vec("postrst_empty",     64'(empty8),     64'h1);
    check_vec("postrst_deq_valid", 64'(deq_valid8), 64'h0);

    // Fresh entry after reset appears at the head
    drive8(2'b01, 32'h55, 32'h0, 2'b00, 1'b0);
    tick();
    drive8(2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
    check_vec("restart_count", 64'(count8),       64'h1);
    check_vec("restart_head",  64'(deq_data8[0]), 64'h55);

    // Depth=6: one single enqueue to offset the pointers, then 2-in/2-out streaming
    // so the write pointer steps 1 -> 3 -> 5 -> 1 across the wrap.
    in_next  = 0;
    out_next = 0;
    enq_valid6 = 2'b01; enq_data6[0] = 32'(in_next); enq_data6[1] = '0; deq_ready6 = 2'b00;
    in_next++;
    tick();
    for (int k = 0; k < 12; k++) begin
      enq_valid6   = 2'b11;
      enq_data6[0] = 32'(in_next);
      enq_data6[1] = 32'(in_next + 1);
      deq_ready6   = 2'b11;
      #1;
      check_vec("s6_count",     64'(count6),     (k == 0) ? 64'h1 : 64'h2);
      check_vec("s6_enq_ready", 64'(enq_ready6), 64'h3);
      check_vec("s6_deq_valid", 64'(deq_valid6), (k == 0) ? 64'h1 : 64'h3);
      for (int i = 0; i < 2; i++) begin
        if (deq_valid6[i]) begin
          check_vec("s6_data", 64'(deq_data6[i]), 64'(out_next));
          out_next++;
        end
      end
      in_next += 2;
      tick();
    end
    enq_valid6 = 2'b00;
    deq_ready6 = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      for (int i = 0; i < 2; i++) begin
        if (deq_valid6[i]) begin
          check_vec("s6_drain_data", 64'(deq_data6[i]), 64'(out_next));
          out_next++;
        end
      end
      tick();
    end
    deq_ready6 = 2'b00;
    #1;
    check_vec("s6_all_out", 64'(out_next), 64'(in_next));
    check_vec("s6_empty",   64'(empty6),   64'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
